id_ex_pipe_stage: RTL and testbench
===================================

# id_ex_pipe_stage

ID→EX pipeline stage of the vector ASIP. Captures the decoded instruction bundle (opcode, vector-ALU select, memory read/write strobes, two operand words) from the ID control unit and presents it to EX with a valid/ready handshake. NOP instructions are squashed here and never reach EX. X-valued vector-ALU selects are sanitised. A flush and an issued-instruction counter are provided.

## Interface
- ARQ, 32, operand word width
- CNT_W, 16, width of issued-instruction counter

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush; drops all held entries
- id_valid_i  in  1  ID bundle valid
- id_ready_o  out  1  stage can accept a bundle
- id_opcode_i  in  4  opcode (0 INCRI, 1 INCRJ, 2 SETN, 3 SUMFV, 4 MULFV, 5 NOP)
- id_vec_alu_op_i  in  1  vector ALU select (0 sum, 1 mul)
- id_r_mem_1_i, id_r_mem_2_i, id_w_mem_2_i, id_w_mem_3_i  in  1 each  memory strobes
- id_op_a_i, id_op_b_i  in  ARQ each  operand words
- ex_valid_o  out  1  EX bundle valid
- ex_ready_i  in  1  EX accepts bundle
- ex_opcode_o, ex_vec_alu_op_o, ex_r_mem_1_o, ex_r_mem_2_o, ex_w_mem_2_o, ex_w_mem_3_o, ex_op_a_o, ex_op_b_o  out  same widths as inputs
- issue_cnt_o  out  CNT_W  bundles accepted by EX

## Operation
- Input transfer: id_valid_i && id_ready_o at a clock edge. Output transfer: ex_valid_o && ex_ready_i at a clock edge.
- NOP squash: an input transfer with opcode 5 is consumed (ready honoured) but writes no entry. Output state is unchanged.
- Opcodes 6–15 are squashed the same way.
- Sanitisation: the stored vec_alu_op is id_vec_alu_op_i for opcodes 3/4, else 0. The stored strobes are forced to 0 for opcodes 0–2.
- Storage: main register (drives ex_*) plus skid register (see Configuration). States: EMPTY (nothing valid), FULL (main valid), SKID (main + skid valid).
  - EMPTY: non-NOP input → FULL.
  - FULL: output transfer without input → EMPTY. Output and input together → FULL with new data. Input without output → SKID (input goes to skid).
  - SKID: output transfer → FULL (skid moves to main). No input accepted.
- id_ready_o = registered, equals !(state==SKID).
- flush_i: next state EMPTY, ignoring any simultaneous input. issue_cnt_o still counts an output transfer occurring in the flush cycle.
- issue_cnt_o increments on each output transfer and wraps 2^CNT_W−1 → 0.
- Payload registers are not cleared on flush, only valids. ex_* data outputs are don't-care while ex_valid_o=0, but are reset to 0.

## Timing
- Reset (rst_n low, async):
  - state EMPTY
  - ex_valid_o=0, id_ready_o=1
  - all ex_* payload outputs 0
  - issue_cnt_o=0
- Latency: input accepted at edge N → ex_valid_o high after edge N.
- No combinational path from ex_ready_i to id_ready_o (skid enabled).
- Throughput: one bundle per cycle while ex_ready_i high.
- ex_* stable while ex_valid_o=1 and ex_ready_i=0.
- Reset released mid-operation: held bundles are lost. No partial transfer is observed.

## Configuration
- ID_EX_SKID_EN defined: two-entry behaviour as above, with registered id_ready_o.
- ID_EX_SKID_EN undefined:
  - No skid register; state SKID is unreachable.
  - id_ready_o = !ex_valid_o || ex_ready_i (combinational).
  - Throughput and latency otherwise identical.

## Structure
- asip_pkg holds:
  - opcode constants OP_INCRI…OP_NOP
  - typedef id_ex_bundle_t (packed struct: opcode, vec_alu_op, four strobes, op_a, op_b; parameterised via ARQ package constant)
  - state enum for EMPTY/FULL/SKID
- Sub-module id_ex_slot: one bundle register with load enable and async reset. It is instantiated for main and (conditionally) skid.

## Test plan
- Reset: assert rst_n=0 mid-cycle → ex_valid_o=0, id_ready_o=1, issue_cnt_o=0 immediately.
- Stream: SUMFV, MULFV, INCRI with ex_ready_i=1.
  - ex_* match one cycle later.
  - vec_alu_op 0,1,0.
  - SUMFV strobes r_mem_2=1 and w_mem_3=1; MULFV strobes r_mem_1=1 and w_mem_2=1.
  - INCRI strobes all 0.
  - issue_cnt_o=3.
- NOP squash: SUMFV, NOP, MULFV back-to-back → EX sees only SUMFV then MULFV; issue_cnt_o=2.
- Backpressure: ex_ready_i=0 for 3 cycles while 3 bundles are offered.
  - Two are held; id_ready_o drops to 0 after the second.
  - ex_* are stable.
  - On release, the order is preserved and no bundle is lost.
- Flush in SKID state with simultaneous valid input → ex_valid_o=0 next cycle, input dropped, id_ready_o=1.
- Wrap: CNT_W=4, 17 transfers → issue_cnt_o=1.

Source files
------------

// File: rtl/asip_pkg.sv
// -----------------------------------------------------------------------------
// asip_pkg
// Shared definitions for the vector ASIP ID->EX boundary:
//   - ARQ          : operand word width
//   - OP_* opcodes : INCRI, INCRJ, SETN, SUMFV, MULFV, NOP (6..15 are unused)
//   - id_ex_bundle_t : decoded instruction bundle carried from ID to EX
//   - id_ex_state_e  : occupancy state of the ID/EX stage (EMPTY/FULL/SKID)
//   - is_squashed()  : true for opcodes that never reach EX
//   - sanitise_bundle() : clears fields that are meaningless for an opcode
// -----------------------------------------------------------------------------
package asip_pkg;

    localparam int unsigned ARQ      = 32;
    localparam int unsigned OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_INCRI = 4'd0;
    localparam logic [OPCODE_W-1:0] OP_INCRJ = 4'd1;
    localparam logic [OPCODE_W-1:0] OP_SETN  = 4'd2;
    localparam logic [OPCODE_W-1:0] OP_SUMFV = 4'd3;
    localparam logic [OPCODE_W-1:0] OP_MULFV = 4'd4;
    localparam logic [OPCODE_W-1:0] OP_NOP   = 4'd5;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic                vec_alu_op;
        logic                r_mem_1;
        logic                r_mem_2;
        logic                w_mem_2;
        logic                w_mem_3;
        logic [ARQ-1:0]      op_a;
        logic [ARQ-1:0]      op_b;
    } id_ex_bundle_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } id_ex_state_e;

    // NOP and every opcode above MULFV are consumed without producing work.
    function automatic logic is_squashed(input logic [OPCODE_W-1:0] opcode);
        return (opcode > OP_MULFV);
    endfunction

    // The ALU select only means something for the vector ops, and the scalar
    // ops (0..2) never touch memory, so those fields are forced to a known 0.
    // Gating by opcode also stops an X on the select from propagating into EX.
    function automatic id_ex_bundle_t sanitise_bundle(input id_ex_bundle_t raw);
        id_ex_bundle_t s;
        s = raw;
        if ((raw.opcode == OP_SUMFV) || (raw.opcode == OP_MULFV)) begin
            s.vec_alu_op = raw.vec_alu_op;
        end else begin
            s.vec_alu_op = 1'b0;
        end
        if (raw.opcode <= OP_SETN) begin
            s.r_mem_1 = 1'b0;
            s.r_mem_2 = 1'b0;
            s.w_mem_2 = 1'b0;
            s.w_mem_3 = 1'b0;
        end else begin
            s.r_mem_1 = raw.r_mem_1;
            s.r_mem_2 = raw.r_mem_2;
            s.w_mem_2 = raw.w_mem_2;
            s.w_mem_3 = raw.w_mem_3;
        end
        return s;
    endfunction

endpackage

// File: rtl/id_ex_slot.sv
// -----------------------------------------------------------------------------
// id_ex_slot
// One bundle-wide register with load enable. Cleared to zero by the async
// reset; holds its contents otherwise (a flush only drops valids upstream).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load_en    : capture d on the next rising edge
//   d          : bundle to store
//   q          : stored bundle
// -----------------------------------------------------------------------------
module id_ex_slot
    import asip_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  id_ex_bundle_t d,
    output id_ex_bundle_t q
);

    id_ex_bundle_t q_r;

    // Bundle storage register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (load_en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/id_ex_pipe_stage.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_stage
// ID->EX pipeline register of the vector ASIP with valid/ready handshake on
// both sides. NOP (and opcodes 6..15) are consumed but never forwarded.
// Build option: define ID_EX_SKID_EN to add a second (skid) entry, which makes
// id_ready_o a register with no path from ex_ready_i. Without it the stage
// holds one entry and id_ready_o = !ex_valid_o || ex_ready_i.
// Parameters:
//   ARQ   : operand width (must equal asip_pkg::ARQ, the bundle width)
//   CNT_W : width of the issued-instruction counter
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush_i               : drop every held entry (payload kept, valids cleared)
//   id_valid_i/id_ready_o : input handshake
//   id_*_i                : decoded bundle from ID
//   ex_valid_o/ex_ready_i : output handshake
//   ex_*_o                : bundle presented to EX
//   issue_cnt_o           : count of output transfers, wraps
// -----------------------------------------------------------------------------
module id_ex_pipe_stage
    import asip_pkg::*;
#(
    parameter int unsigned ARQ   = asip_pkg::ARQ,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                id_valid_i,
    output logic                id_ready_o,
    input  logic [OPCODE_W-1:0] id_opcode_i,
    input  logic                id_vec_alu_op_i,
    input  logic                id_r_mem_1_i,
    input  logic                id_r_mem_2_i,
    input  logic                id_w_mem_2_i,
    input  logic                id_w_mem_3_i,
    input  logic [ARQ-1:0]      id_op_a_i,
    input  logic [ARQ-1:0]      id_op_b_i,
    output logic                ex_valid_o,
    input  logic                ex_ready_i,
    output logic [OPCODE_W-1:0] ex_opcode_o,
    output logic                ex_vec_alu_op_o,
    output logic                ex_r_mem_1_o,
    output logic                ex_r_mem_2_o,
    output logic                ex_w_mem_2_o,
    output logic                ex_w_mem_3_o,
    output logic [ARQ-1:0]      ex_op_a_o,
    output logic [ARQ-1:0]      ex_op_b_o,
    output logic [CNT_W-1:0]    issue_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    id_ex_state_e     state_r;
    id_ex_state_e     state_s;
    logic             ex_valid_r;
    logic             id_ready_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             in_keep_s;
    logic             main_load_s;
    id_ex_bundle_t    raw_bundle_s;
    id_ex_bundle_t    in_bundle_s;
    id_ex_bundle_t    main_d_s;
    id_ex_bundle_t    main_q_s;
    logic [CNT_W-1:0] issue_cnt_r;

    // Collect the ID fields into one bundle.
    always_comb begin
        raw_bundle_s            = '0;
        raw_bundle_s.opcode     = id_opcode_i;
        raw_bundle_s.vec_alu_op = id_vec_alu_op_i;
        raw_bundle_s.r_mem_1    = id_r_mem_1_i;
        raw_bundle_s.r_mem_2    = id_r_mem_2_i;
        raw_bundle_s.w_mem_2    = id_w_mem_2_i;
        raw_bundle_s.w_mem_3    = id_w_mem_3_i;
        raw_bundle_s.op_a       = id_op_a_i;
        raw_bundle_s.op_b       = id_op_b_i;
    end

    assign in_bundle_s = sanitise_bundle(raw_bundle_s);
    assign in_xfer_s   = id_valid_i && id_ready_s;
    assign out_xfer_s  = ex_valid_r && ex_ready_i;
    // A squashed opcode still completes its input handshake, it just stores nothing.
    assign in_keep_s   = in_xfer_s && !is_squashed(id_opcode_i);

`ifdef ID_EX_SKID_EN
    logic          skid_load_s;
    logic          main_from_skid_s;
    logic          id_ready_r;
    id_ex_bundle_t skid_q_s;

    id_ex_slot u_skid_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (skid_load_s),
        .d       (in_bundle_s),
        .q       (skid_q_s)
    );

    // Ready is computed from the next state so it never depends on ex_ready_i
    // within the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ready_r <= 1'b1;
        end else begin
            id_ready_r <= (state_s != ST_SKID);
        end
    end

    assign id_ready_s = id_ready_r;
    assign main_d_s   = main_from_skid_s ? skid_q_s : in_bundle_s;
`else
    assign id_ready_s = !ex_valid_r || ex_ready_i;
    assign main_d_s   = in_bundle_s;
`endif

    id_ex_slot u_main_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_en (main_load_s),
        .d       (main_d_s),
        .q       (main_q_s)
    );

    // Next-state and slot load decode.
    always_comb begin
        state_s          = state_r;
        main_load_s      = 1'b0;
`ifdef ID_EX_SKID_EN
        skid_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
`endif
        if (flush_i) begin
            state_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_keep_s) begin
                        state_s     = ST_FULL;
                        main_load_s = 1'b1;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s && in_keep_s) begin
                        state_s     = ST_FULL;
                        main_load_s = 1'b1;
                    end else if (out_xfer_s) begin
                        state_s = ST_EMPTY;
                    end else if (in_keep_s) begin
`ifdef ID_EX_SKID_EN
                        state_s     = ST_SKID;
                        skid_load_s = 1'b1;
`else
                        // Not reachable: ready is low while full and stalled.
                        state_s = ST_FULL;
`endif
                    end else begin
                        state_s = ST_FULL;
                    end
                end
                ST_SKID: begin
`ifdef ID_EX_SKID_EN
                    if (out_xfer_s) begin
                        state_s          = ST_FULL;
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                    end else begin
                        state_s = ST_SKID;
                    end
`else
                    state_s = ST_EMPTY;
`endif
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state and output valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_EMPTY;
            ex_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            ex_valid_r <= (state_s != ST_EMPTY);
        end
    end

    // Issued-instruction counter; an output transfer in a flush cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_r <= '0;
        end else if (out_xfer_s) begin
            issue_cnt_r <= issue_cnt_r + CNT_ONE;
        end else begin
            issue_cnt_r <= issue_cnt_r;
        end
    end

    assign id_ready_o      = id_ready_s;
    assign ex_valid_o      = ex_valid_r;
    assign ex_opcode_o     = main_q_s.opcode;
    assign ex_vec_alu_op_o = main_q_s.vec_alu_op;
    assign ex_r_mem_1_o    = main_q_s.r_mem_1;
    assign ex_r_mem_2_o    = main_q_s.r_mem_2;
    assign ex_w_mem_2_o    = main_q_s.w_mem_2;
    assign ex_w_mem_3_o    = main_q_s.w_mem_3;
    assign ex_op_a_o       = main_q_s.op_a;
    assign ex_op_b_o       = main_q_s.op_b;
    assign issue_cnt_o     = issue_cnt_r;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_stage
// Directed test of id_ex_pipe_stage with hand-computed expectations. The DUT
// uses CNT_W=4 so counter wrap is reachable; skid-dependent expectations
// follow ID_EX_SKID_EN.
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_stage;

    logic        clk;
    logic        rst_n;
    logic        flush_i;
    logic        id_valid_i;
    logic        id_ready_o;
    logic [3:0]  id_opcode_i;
    logic        id_vec_alu_op_i;
    logic        id_r_mem_1_i;
    logic        id_r_mem_2_i;
    logic        id_w_mem_2_i;
    logic        id_w_mem_3_i;
    logic [31:0] id_op_a_i;
    logic [31:0] id_op_b_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [3:0]  ex_opcode_o;
    logic        ex_vec_alu_op_o;
    logic        ex_r_mem_1_o;
    logic        ex_r_mem_2_o;
    logic        ex_w_mem_2_o;
    logic        ex_w_mem_3_o;
    logic [31:0] ex_op_a_o;
    logic [31:0] ex_op_b_o;
    logic [3:0]  issue_cnt_o;
    logic [79:0] ex_pl;

    int n_vec = 0;
    int n_err = 0;

    id_ex_pipe_stage #(.ARQ(32), .CNT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .id_valid_i      (id_valid_i),
        .id_ready_o      (id_ready_o),
        .id_opcode_i     (id_opcode_i),
        .id_vec_alu_op_i (id_vec_alu_op_i),
        .id_r_mem_1_i    (id_r_mem_1_i),
        .id_r_mem_2_i    (id_r_mem_2_i),
        .id_w_mem_2_i    (id_w_mem_2_i),
        .id_w_mem_3_i    (id_w_mem_3_i),
        .id_op_a_i       (id_op_a_i),
        .id_op_b_i       (id_op_b_i),
        .ex_valid_o      (ex_valid_o),
        .ex_ready_i      (ex_ready_i),
        .ex_opcode_o     (ex_opcode_o),
        .ex_vec_alu_op_o (ex_vec_alu_op_o),
        .ex_r_mem_1_o    (ex_r_mem_1_o),
        .ex_r_mem_2_o    (ex_r_mem_2_o),
        .ex_w_mem_2_o    (ex_w_mem_2_o),
        .ex_w_mem_3_o    (ex_w_mem_3_o),
        .ex_op_a_o       (ex_op_a_o),
        .ex_op_b_o       (ex_op_b_o),
        .issue_cnt_o     (issue_cnt_o)
    );

    assign ex_pl = {7'd0, ex_opcode_o, ex_vec_alu_op_o, ex_r_mem_1_o, ex_r_mem_2_o,
                    ex_w_mem_2_o, ex_w_mem_3_o, ex_op_a_o, ex_op_b_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach its end");
        $fatal(1);
    end

    // Strobe nibble order is {r_mem_1, r_mem_2, w_mem_2, w_mem_3}.
    function automatic logic [79:0] pl(input logic [3:0] op, input logic vop,
                                       input logic [3:0] st, input logic [31:0] a,
                                       input logic [31:0] b);
        return {7'd0, op, vop, st, a, b};
    endfunction

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ex(input string tag, input logic [79:0] exp);
        check_eq({tag, "_valid"}, {79'd0, ex_valid_o}, 80'd1);
        check_eq({tag, "_data"}, ex_pl, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic vop, input logic [3:0] st,
                        input logic [31:0] a, input logic [31:0] b);
        id_valid_i      = 1'b1;
        id_opcode_i     = op;
        id_vec_alu_op_i = vop;
        {id_r_mem_1_i, id_r_mem_2_i, id_w_mem_2_i, id_w_mem_3_i} = st;
        id_op_a_i       = a;
        id_op_b_i       = b;
    endtask

    task automatic idle();
        id_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic chk_valid(input string tag, input logic exp);
        check_eq(tag, {79'd0, ex_valid_o}, {79'd0, exp});
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        check_eq(tag, {79'd0, id_ready_o}, {79'd0, exp});
    endtask

    task automatic chk_cnt(input string tag, input logic [3:0] exp);
        check_eq(tag, {76'd0, issue_cnt_o}, {76'd0, exp});
    endtask

    initial begin
        logic [79:0] e_sum;
        logic [79:0] e_mul;
        logic [79:0] e_inc;
        logic [79:0] e_b1;
        logic [79:0] e_b2;
        logic [79:0] e_b3;
        e_sum = pl(4'd3, 1'b0, 4'b0101, 32'h1111_0001, 32'h2222_0001);
        e_mul = pl(4'd4, 1'b1, 4'b1010, 32'h1111_0002, 32'h2222_0002);
        e_inc = pl(4'd0, 1'b0, 4'b0000, 32'h1111_0003, 32'h2222_0003);
        e_b1  = pl(4'd3, 1'b1, 4'b0101, 32'h0000_00B1, 32'h0000_01B1);
        e_b2  = pl(4'd4, 1'b1, 4'b1010, 32'h0000_00B2, 32'h0000_01B2);
        e_b3  = pl(4'd2, 1'b0, 4'b0000, 32'h0000_00B3, 32'h0000_01B3);

        rst_n = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;
        send(4'd0, 1'b0, 4'b0000, 32'd0, 32'd0);
        idle();
        #12;
        chk_valid("rst_valid", 1'b0);
        chk_ready("rst_ready", 1'b1);
        chk_cnt("rst_cnt", 4'd0);
        check_eq("rst_payload", ex_pl, 80'd0);
        tick();
        rst_n = 1'b1;

        // Stream SUMFV, MULFV, INCRI (INCRI offered with select/strobes set).
        send(4'd3, 1'b0, 4'b0101, 32'h1111_0001, 32'h2222_0001);
        tick(); check_ex("str_sum", e_sum);
        send(4'd4, 1'b1, 4'b1010, 32'h1111_0002, 32'h2222_0002);
        tick(); check_ex("str_mul", e_mul);
        send(4'd0, 1'b1, 4'b1111, 32'h1111_0003, 32'h2222_0003);
        tick(); check_ex("str_incri", e_inc);
        idle();
        tick(); chk_valid("str_drain", 1'b0); chk_cnt("str_cnt", 4'd3);

        // NOP squash.
        do_reset();
        send(4'd3, 1'b0, 4'b0101, 32'h1111_0001, 32'h2222_0001);
        tick(); check_ex("nop_sum", e_sum);
        send(4'd5, 1'b1, 4'b1111, 32'hDEAD_0005, 32'hDEAD_0005);
        chk_ready("nop_ready", 1'b1);
        tick(); chk_valid("nop_gap", 1'b0);
        send(4'd4, 1'b1, 4'b1010, 32'h1111_0002, 32'h2222_0002);
        tick(); check_ex("nop_mul", e_mul);
        send(4'd9, 1'b1, 4'b1111, 32'hDEAD_0009, 32'hDEAD_0009);
        tick(); chk_valid("op9_squash", 1'b0); chk_cnt("nop_cnt", 4'd2);
        idle();

        // Backpressure: three bundles offered while EX stalls.
        do_reset();
        ex_ready_i = 1'b0;
        send(4'd3, 1'b1, 4'b0101, 32'h0000_00B1, 32'h0000_01B1);
        chk_ready("bp_ready0", 1'b1);
`ifdef ID_EX_SKID_EN
        tick(); check_ex("bp_p1", e_b1); chk_ready("bp_ready1", 1'b1);
        send(4'd4, 1'b1, 4'b1010, 32'h0000_00B2, 32'h0000_01B2);
        tick(); check_ex("bp_p2", e_b1); chk_ready("bp_ready2", 1'b0);
        send(4'd2, 1'b1, 4'b1111, 32'h0000_00B3, 32'h0000_01B3);
        tick(); check_ex("bp_p3", e_b1); chk_ready("bp_ready3", 1'b0);
        chk_cnt("bp_cnt3", 4'd0);
        ex_ready_i = 1'b1;
        tick(); check_ex("bp_p4", e_b2); chk_cnt("bp_cnt4", 4'd1);
`else
        tick(); check_ex("bp_p1", e_b1); chk_ready("bp_ready1", 1'b0);
        send(4'd4, 1'b1, 4'b1010, 32'h0000_00B2, 32'h0000_01B2);
        tick(); check_ex("bp_p2", e_b1); chk_ready("bp_ready2", 1'b0);
        tick(); check_ex("bp_p3", e_b1); chk_cnt("bp_cnt3", 4'd0);
        ex_ready_i = 1'b1;
        #1; chk_ready("bp_ready_rel", 1'b1);
        tick(); check_ex("bp_p4", e_b2); chk_cnt("bp_cnt4", 4'd1);
        send(4'd2, 1'b1, 4'b1111, 32'h0000_00B3, 32'h0000_01B3);
`endif
        tick(); check_ex("bp_p5", e_b3); chk_cnt("bp_cnt5", 4'd2);
        idle();
        tick(); chk_valid("bp_drain", 1'b0); chk_cnt("bp_cnt6", 4'd3);

        // Flush while stalled with a simultaneous valid input.
        do_reset();
        ex_ready_i = 1'b0;
        send(4'd3, 1'b1, 4'b0101, 32'h0000_00B1, 32'h0000_01B1);
        tick();
`ifdef ID_EX_SKID_EN
        send(4'd4, 1'b1, 4'b1010, 32'h0000_00B2, 32'h0000_01B2);
        tick(); chk_ready("fl_skid_ready", 1'b0);
`else
        chk_ready("fl_full_ready", 1'b0);
`endif
        flush_i = 1'b1;
        send(4'd2, 1'b1, 4'b1111, 32'h0000_00B3, 32'h0000_01B3);
        tick();
        flush_i = 1'b0;
        idle();
        chk_valid("fl_valid", 1'b0); chk_ready("fl_ready", 1'b1); chk_cnt("fl_cnt", 4'd0);
        ex_ready_i = 1'b1;
        tick(); chk_valid("fl_dropped", 1'b0);
        // Flush coinciding with an output transfer still counts it.
        send(4'd3, 1'b1, 4'b0101, 32'h0000_00B1, 32'h0000_01B1);
        tick(); check_ex("fl2_load", e_b1);
        idle();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk_valid("fl2_valid", 1'b0); chk_cnt("fl2_cnt", 4'd1);

        // Counter wrap: 17 transfers on a 4-bit counter.
        do_reset();
        ex_ready_i = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(4'd3, 1'b0, 4'b0101, i, 32'h0000_0100);
            tick();
        end
        check_ex("wrap_last", pl(4'd3, 1'b0, 4'b0101, 32'd16, 32'h0000_0100));
        chk_cnt("wrap_cnt16", 4'd0);
        idle();
        tick(); chk_cnt("wrap_cnt17", 4'd1);

        // Asynchronous reset mid-cycle with a bundle held.
        ex_ready_i = 1'b0;
        send(4'd4, 1'b1, 4'b1010, 32'h1111_0002, 32'h2222_0002);
        tick(); check_ex("ar_hold", e_mul);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk_valid("ar_valid", 1'b0); chk_ready("ar_ready", 1'b1);
        chk_cnt("ar_cnt", 4'd0); check_eq("ar_payload", ex_pl, 80'd0);
        #1;
        rst_n = 1'b1;
        tick(); chk_valid("ar_after", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
